// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam int GNT_I_IDX = 0;
    localparam int GNT_D_IDX = 1;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // One-hot {D,I} grant vector for a given arbiter state.
    function automatic logic [1:0] state_to_grant(input arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            GNT_I:   g[GNT_I_IDX] = 1'b1;
            GNT_D:   g[GNT_D_IDX] = 1'b1;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Per-grant stall counter: cleared while the arbiter is idle, counts cycles the
// slave holds waitrequest, saturates at LIMIT and flags expiry. LIMIT=0 disables it.
module arb_timeout_counter #(
    parameter int LIMIT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W   = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
    localparam bit              ACTIVE  = (LIMIT > 0);

    logic [CNT_W-1:0] count_r;

    // Saturating stall count; never wraps past LIMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && ACTIVE && (count_r != LIMIT_V)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = ACTIVE && (count_r == LIMIT_V);

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Two-master Avalon-MM arbiter: shares one RAM port between instruction fetch (I)
// and load/store (D). One grant per transaction, IDLE between transactions.
// Build option: define ARB_ROUND_ROBIN_EN for alternating priority on contention;
// otherwise D has fixed priority over I.
module avalon_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitreq,
    output logic [DATA_W-1:0]   i_readdata,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteen,
    output logic                d_waitreq,
    output logic [DATA_W-1:0]   d_readdata,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,
    output logic [1:0]          grant,
    output logic                timeout_err,
    output logic                proto_err
);

    localparam int               BE_W    = DATA_W / 8;
    localparam logic [DATA_W-1:0] TO_DATA = DATA_W'(TIMEOUT_DATA);

    arb_state_t state_r;
    logic [1:0] grant_r;
    logic       timeout_err_r;
    logic       proto_err_r;
    logic       d_req_s;
    logic       i_req_s;
    logic       owner_req_s;
    logic       pick_d_s;
    logic       expired_s;

    assign d_req_s = d_read | d_write;
    assign i_req_s = i_read;

`ifdef ARB_ROUND_ROBIN_EN
    // Last master served (1 = D); reset value favours D on the first contention.
    logic last_d_r;

    // Contention goes to whichever master was not served last.
    always_comb begin
        pick_d_s = (d_req_s && i_req_s) ? ~last_d_r : d_req_s;
    end
`else
    // Fixed priority: D wins whenever it requests.
    always_comb begin
        pick_d_s = d_req_s;
    end
`endif

    // Request line of the current owner.
    always_comb begin
        owner_req_s = 1'b0;
        case (state_r)
            GNT_I:   owner_req_s = i_req_s;
            GNT_D:   owner_req_s = d_req_s;
            default: owner_req_s = 1'b0;
        endcase
    end

    arb_timeout_counter #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_r == IDLE),
        .enable  ((state_r != IDLE) && waitrequest),
        .expired (expired_s)
    );

    // Arbitration FSM with registered grant and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            grant_r       <= 2'b00;
            timeout_err_r <= 1'b0;
            proto_err_r   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_r      <= 1'b0;
`endif
        end else begin
            if (d_read && d_write) begin
                proto_err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (d_req_s || i_req_s) begin
                        if (pick_d_s) begin
                            state_r <= GNT_D;
                            grant_r <= state_to_grant(GNT_D);
                        end else begin
                            state_r <= GNT_I;
                            grant_r <= state_to_grant(GNT_I);
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (!owner_req_s) begin
                        // Owner abandoned the transfer: release quietly.
                        state_r <= IDLE;
                        grant_r <= 2'b00;
                    end else if (expired_s) begin
                        state_r       <= IDLE;
                        grant_r       <= 2'b00;
                        timeout_err_r <= 1'b1;
                    end else if (!waitrequest) begin
                        state_r  <= IDLE;
                        grant_r  <= 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_r <= (state_r == GNT_D);
`endif
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant_r <= 2'b00;
                end
            endcase
        end
    end

    // Route the owner's bus onto the slave; a timeout fakes a completion with marker data.
    always_comb begin
        address    = {ADDR_W{1'b0}};
        read       = 1'b0;
        write      = 1'b0;
        writedata  = {DATA_W{1'b0}};
        byteenable = {BE_W{1'b0}};
        i_waitreq  = 1'b1;
        d_waitreq  = 1'b1;
        i_readdata = {DATA_W{1'b0}};
        d_readdata = {DATA_W{1'b0}};
        case (state_r)
            GNT_I: begin
                address    = i_address;
                read       = i_read & ~expired_s;
                byteenable = {BE_W{1'b1}};
                i_waitreq  = expired_s ? 1'b0 : waitrequest;
                i_readdata = expired_s ? TO_DATA : readdata;
            end
            GNT_D: begin
                address    = d_address;
                write      = d_write & ~expired_s;
                read       = d_read & ~d_write & ~expired_s;
                writedata  = d_writedata;
                byteenable = d_byteen;
                d_waitreq  = expired_s ? 1'b0 : waitrequest;
                d_readdata = expired_s ? TO_DATA : readdata;
            end
            default: begin
                address = {ADDR_W{1'b0}};
            end
        endcase
    end

    assign grant       = grant_r;
    assign timeout_err = timeout_err_r;
    assign proto_err   = proto_err_r;

endmodule
